a2_bridge_scheduler: RTL
========================

Name: a2_bridge_scheduler

Overview:
Arbitrates the shared 8-bit multiplexed A2 bridge port (sel/rd_n/wr_n/d) among NUM_REQ requesters. Typical requesters are bus address/data sampling, bus data drive, GPIO control writes and DIP/config reads. Each granted requester gets one atomic, fixed-sequence read or write transaction. Between transactions the block parks the bridge on group 0 and samples the control lines. Sits between the apple bus front end and the bridge pins.

Parameters:
NUM_REQ, 4, number of requesters (>=2); index 0 is the timing-critical bus sampler.
RD_WAIT, 1, hold cycles between select/rd_n assertion and data capture (>=1).
WR_PULSE, 1, cycles wr_n is held low (>=1).

Ports:
clk_logic  in  1  logic clock
device_reset_n  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  transaction request, held high until done
req_we_i  in  NUM_REQ  1=write, 0=read
req_sel_i  in  3*NUM_REQ  bridge group select per requester
req_wdata_i  in  8*NUM_REQ  write data per requester
gnt_o  out  NUM_REQ  one-hot grant, high for the whole transaction
done_o  out  NUM_REQ  one-cycle completion pulse
rdata_o  out  8  read data, valid while done_o of a read is high, held after
busy_o  out  1  transaction in progress (state != IDLE)
bridge_sel_o  out  3  bridge group select
bridge_rd_n_o  out  1  bridge read strobe
bridge_wr_n_o  out  1  bridge write strobe
bridge_d_o  out  8  bridge write data
bridge_d_oe_o  out  1  bridge data output enable
bridge_d_i  in  8  bridge read data
ctrl_in_o  out  8  last control-line sample taken while idle

Behaviour:
- One clock, clk_logic; reset is asynchronous, active-low (device_reset_n). All outputs are registered.
- Reset values: state IDLE; gnt_o=0; done_o=0; rdata_o=0; busy_o=0; bridge_sel_o=0; bridge_rd_n_o=1; bridge_wr_n_o=1; bridge_d_o=0; bridge_d_oe_o=0; ctrl_in_o=8'hFF; round-robin pointer=1.
- States: IDLE, RD_HOLD, RD_CAP, WR_SETUP, WR_PULSE, WR_RECOVER.
- Arbitration happens only in IDLE:
  - req_i[0] always wins.
  - Otherwise round-robin over 1..NUM_REQ-1, searching upward from the pointer with wrap to 1.
  - After granting i>=1, pointer=i+1, wrapping to 1 past NUM_REQ-1. Granting 0 leaves the pointer unchanged.
  - sel/we/wdata are latched at grant; later changes are ignored.
- Read, request seen at edge k:
  - k+1: gnt set, busy=1, sel=req_sel, rd_n=0, state RD_HOLD.
  - Hold for RD_WAIT cycles.
  - k+2+RD_WAIT: rdata_o<=bridge_d_i, done pulse, gnt=0, sel=0, rd_n=1, state IDLE.
- Write, request seen at edge k:
  - k+1: gnt, sel, d_o=wdata, d_oe=1, wr_n=1 (WR_SETUP).
  - k+2: wr_n=0 for WR_PULSE cycles (WR_PULSE).
  - k+2+WR_PULSE: wr_n=1, d_oe and sel held (WR_RECOVER).
  - k+3+WR_PULSE: d_oe=0, sel=0, done pulse, gnt=0, IDLE.
- IDLE is at least one cycle between transactions, so the earliest next grant edge is the done edge +1.
- Idle parking: sel=0, rd_n=0, wr_n=1, d_oe=0. ctrl_in_o<=bridge_d_i on every IDLE edge where the previous cycle was also IDLE. The first idle cycle after a transaction is settling time, not a sample.
- req_i dropped before grant: withdrawn, no transaction. Dropped after grant: the transaction still completes and done still pulses.
- Continuous req_i[0] starves the others by design.
- Reset mid-transaction: outputs return to reset values asynchronously, no done pulse, state IDLE on release.
- rd_n and wr_n are never low simultaneously. d_oe is never high during a read.

Optional Feature:
A2_BRIDGE_SCHED_IDLE_SAMPLE_EN
- Defined: idle parking drives rd_n=0 and ctrl_in_o samples as described above.
- Undefined: idle drives rd_n=1, ctrl_in_o stays 8'hFF permanently, and the bridge is fully quiescent between transactions.

Test Plan:
1. req_i[1] read, sel=2, bridge_d_i=8'h5A, RD_WAIT=1 -> gnt_o=4'b0010 and sel=2/rd_n=0 at k+1..k+2; done_o[1] at k+3 with rdata_o=8'h5A; sel=0 after.
2. req_i[2] write, sel=1, wdata=8'hC3 -> d_o=8'hC3 and d_oe=1 for k+1..k+3; wr_n low only at k+2; done_o[2] at k+4; d_oe=0 at k+4.
3. req_i=4'b0111 simultaneously, held -> grants in order 0,1,2, each separated by one IDLE. Then assert req 1 and 2 together (pointer=3) -> grant 1.
4. Idle with bridge_d_i=8'hA5 (macro defined) -> ctrl_in_o=8'hA5 after the second idle edge. Macro undefined -> rd_n=1 in idle, ctrl_in_o stays 8'hFF.
5. device_reset_n low during WR_PULSE -> wr_n=1, d_oe=0, gnt=0 with no clock edge; no done; IDLE after release.
6. RD_WAIT=3 read with bridge_d_i=8'h11 -> rd_n low k+1..k+4; done and rdata_o=8'h11 at k+5.

Source files
------------

// File: rtl/a2_bridge_scheduler.sv
// Shares the multiplexed A2 bridge port among NUM_REQ requesters, one atomic read/write each.
// Optional idle sampling of the control lines: define A2_BRIDGE_SCHED_IDLE_SAMPLE_EN.
module a2_bridge_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic                   clk_logic,
  input  logic                   device_reset_n,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     req_we_i,
  input  logic [3*NUM_REQ-1:0]   req_sel_i,
  input  logic [8*NUM_REQ-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [7:0]             rdata_o,
  output logic                   busy_o,
  output logic [2:0]             bridge_sel_o,
  output logic                   bridge_rd_n_o,
  output logic                   bridge_wr_n_o,
  output logic [7:0]             bridge_d_o,
  output logic                   bridge_d_oe_o,
  input  logic [7:0]             bridge_d_i,
  output logic [7:0]             ctrl_in_o
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_RD_HOLD    = 3'd1;
  localparam logic [2:0] S_RD_CAP     = 3'd2;
  localparam logic [2:0] S_WR_SETUP   = 3'd3;
  localparam logic [2:0] S_WR_PULSE   = 3'd4;
  localparam logic [2:0] S_WR_RECOVER = 3'd5;

  localparam int unsigned IW   = $clog2(NUM_REQ);
  localparam int unsigned CMAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int unsigned CW   = $clog2(CMAX + 1);

`ifdef A2_BRIDGE_SCHED_IDLE_SAMPLE_EN
  localparam logic IDLE_RD_N = 1'b0;
  localparam logic SAMPLE_EN = 1'b1;
`else
  localparam logic IDLE_RD_N = 1'b1;
  localparam logic SAMPLE_EN = 1'b0;
`endif

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               idle_q, idle_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic [2:0]         sel_q, sel_d;
  logic               rd_n_q, rd_n_d;
  logic               wr_n_q, wr_n_d;
  logic [7:0]         d_q, d_d;
  logic               doe_q, doe_d;
  logic [7:0]         ctrl_q, ctrl_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand_idx;

  // Requester 0 has absolute priority; the rest rotate starting at ptr_q, wrapping back to 1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    if (req_i[0]) begin
      win_found = 1'b1;
    end else begin
      for (int unsigned o = 0; o < NUM_REQ - 1; o++) begin
        cand_idx = IW'(((32'(ptr_q) - 1 + o) % (NUM_REQ - 1)) + 1);
        if (!win_found && req_i[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idle_d  = (state_q == S_IDLE);
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    sel_d   = sel_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    d_d     = d_q;
    doe_d   = doe_q;
    ctrl_d  = ctrl_q;

    // The first idle cycle after a transaction only lets the bridge settle.
    if (SAMPLE_EN && (state_q == S_IDLE) && idle_q) begin
      ctrl_d = bridge_d_i;
    end

    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        sel_d  = '0;
        rd_n_d = IDLE_RD_N;
        wr_n_d = 1'b1;
        doe_d  = 1'b0;
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          busy_d         = 1'b1;
          sel_d          = req_sel_i[3*win_idx +: 3];
          if (win_idx != '0) begin
            ptr_d = (32'(win_idx) == NUM_REQ - 1) ? IW'(1) : win_idx + 1'b1;
          end
          if (req_we_i[win_idx]) begin
            d_d     = req_wdata_i[8*win_idx +: 8];
            doe_d   = 1'b1;
            rd_n_d  = 1'b1;
            state_d = S_WR_SETUP;
          end else begin
            rd_n_d  = 1'b0;
            cnt_d   = CW'(RD_WAIT - 1);
            state_d = S_RD_HOLD;
          end
        end
      end
      S_RD_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_RD_CAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_CAP: begin
        rdata_d = bridge_d_i;
        done_d  = gnt_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        sel_d   = '0;
        rd_n_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_WR_SETUP: begin
        wr_n_d  = 1'b0;
        cnt_d   = CW'(WR_PULSE - 1);
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          wr_n_d  = 1'b1;
          state_d = S_WR_RECOVER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_RECOVER: begin
        doe_d   = 1'b0;
        sel_d   = '0;
        done_d  = gnt_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        sel_d   = '0;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        doe_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(1);
      idle_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      sel_q   <= '0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      d_q     <= '0;
      doe_q   <= 1'b0;
      ctrl_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idle_q  <= idle_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      d_q     <= d_d;
      doe_q   <= doe_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = busy_q;
  assign bridge_sel_o  = sel_q;
  assign bridge_rd_n_o = rd_n_q;
  assign bridge_wr_n_o = wr_n_q;
  assign bridge_d_o    = d_q;
  assign bridge_d_oe_o = doe_q;
  assign ctrl_in_o     = ctrl_q;

endmodule
